sccb_reg_writer: RTL and testbench

//  SCCB/I2C write master for the OV5640. One request writes one 8-bit value to one 16-bit sensor register.

---
 rtl/sccb_reg_writer_if.sv | 12 +
 rtl/sccb_reg_writer.sv | 130 +++++++++++++
 tb/tb_sccb_reg_writer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sccb_reg_writer_if.sv
// Request/status handshake between the init sequencer (master) and the SCCB writer (slave).
interface sccb_reg_writer_if;
   logic        start;
   logic [15:0] reg_addr;
   logic [7:0]  reg_data;
   logic        busy;
   logic        done;
   logic        ack_err;

   modport master (output start, reg_addr, reg_data, input busy, done, ack_err);
   modport slave  (input start, reg_addr, reg_data, output busy, done, ack_err);
endinterface

// File: rtl/sccb_reg_writer.sv
// SCCB write master for the OV5640: one request writes DEV_ADDR, a 16-bit register address and one data byte.
// Every bus step lasts one quarter of an SCL period; scl and the sda enable are registered.
module sccb_reg_writer #(
   parameter int unsigned CLK_HZ   = 25_000_000,
   parameter int unsigned SCL_HZ   = 100_000,
   parameter logic [7:0]  DEV_ADDR = 8'h78
) (
   input  logic             meg25,
   input  logic             rst_n,
   sccb_reg_writer_if.slave req,
   output logic             scl,
   inout  wire              sda
);
   localparam int unsigned Q  = CLK_HZ / (4 * SCL_HZ);
   localparam int unsigned CW = $clog2(Q);

   typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [1:0]    ph_q, ph_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic [31:0]   sh_q, sh_d;
   logic          scl_q, oe_q, busy_q, done_q, err_q;
   logic          scl_d, oe_d, tick, accept;

   assign tick   = (cnt_q == CW'(Q - 1));
   assign accept = req.start && !busy_q;

   assign scl         = scl_q;
   assign sda         = oe_q ? 1'b0 : 1'bz;
   assign req.busy    = busy_q;
   assign req.done    = done_q;
   assign req.ack_err = err_q;

   // Step sequencing: only consumed on the last cycle of a quarter.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q + 2'd1;
      bit_d   = bit_q;
      byte_d  = byte_q;
      sh_d    = sh_q;
      case (state_q)
         START: if (ph_q == 2'd1) begin
            state_d = BYTE;
            ph_d    = 2'd0;
         end
         BYTE: if (ph_q == 2'd3) begin
            sh_d  = {sh_q[30:0], 1'b0};
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) state_d = ACK;
         end
         ACK: if (ph_q == 2'd3) begin
            if (byte_q == 2'd3) state_d = STOP;
            else begin
               state_d = BYTE;
               byte_d  = byte_q + 2'd1;
            end
         end
         STOP: if (ph_q == 2'd3) state_d = IDLE;
         default: ph_d = 2'd0;
      endcase

      // Pad levels for the step being entered; sh_d[31] is already the next bit.
      scl_d = 1'b1;
      oe_d  = 1'b0;
      case (state_d)
         START: oe_d = ph_d[0];
         BYTE: begin
            scl_d = ph_d[1];
            oe_d  = ~sh_d[31];
         end
         ACK:  scl_d = ph_d[1];
         STOP: begin
            scl_d = (ph_d != 2'd0);
            oe_d  = ~ph_d[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge meg25) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ph_q    <= 2'd0;
         bit_q   <= 3'd7;
         byte_q  <= 2'd0;
         sh_q    <= '0;
         scl_q   <= 1'b1;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (accept) begin
               state_q <= START;
               cnt_q   <= '0;
               ph_q    <= 2'd0;
               bit_q   <= 3'd7;
               byte_q  <= 2'd0;
               sh_q    <= {DEV_ADDR & 8'hFE, req.reg_addr, req.reg_data};
               err_q   <= 1'b0;
               busy_q  <= 1'b1;
               scl_q   <= 1'b1;
               oe_q    <= 1'b0;
            end
         end else begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
            if (state_q == ACK && ph_q == 2'd2 && tick) err_q <= err_q | sda;
            if (tick) begin
               state_q <= state_d;
               ph_q    <= ph_d;
               bit_q   <= bit_d;
               byte_q  <= byte_d;
               sh_q    <= sh_d;
               scl_q   <= scl_d;
               oe_q    <= oe_d;
               if (state_d == IDLE) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_sccb_reg_writer.sv
// Directed bench for sccb_reg_writer: a small SCCB slave acks selected slots, a bus monitor
// records bits on scl rises and counts START/STOP conditions.
module tb_sccb_reg_writer;
   logic meg25 = 1'b0;
   logic rst_n = 1'b0;
   logic scl;
   wire  sda;
   logic slave_pull = 1'b0;
   logic [3:0] ack_pull = 4'hF;

   sccb_reg_writer_if req_if();

   sccb_reg_writer #(.CLK_HZ(25_000_000), .SCL_HZ(100_000), .DEV_ADDR(8'h78)) dut (
      .meg25(meg25), .rst_n(rst_n), .req(req_if), .scl(scl), .sda(sda));

   pullup (sda);
   assign sda = slave_pull ? 1'b0 : 1'bz;

   always #5 meg25 = ~meg25;

   int   total = 0, bad = 0;
   int   ndone = 0, nstart = 0, nstop = 0, rise_cnt = 0;
   bit   mon_en = 1'b1;
   logic scl_p = 1'b1, sda_p = 1'b1;
   logic cap[$];

   always @(negedge meg25) begin
      if (req_if.done === 1'b1) ndone++;
      if (mon_en) begin
         if (scl && scl_p && sda_p && !sda) begin nstart++; rise_cnt = 0; end
         if (scl && scl_p && !sda_p && sda) nstop++;
         if (scl && !scl_p) begin cap.push_back(sda); rise_cnt++; end
         if (!scl && scl_p)
            slave_pull = (rise_cnt % 9 == 8 && rise_cnt < 36) ? ack_pull[2'(rise_cnt / 9)] : 1'b0;
      end
      scl_p = scl;
      sda_p = sda;
   end

   function automatic logic [36:0] exp_bits(logic [15:0] a, logic [7:0] d, logic [3:0] pull);
      return {8'h78, ~pull[0], a[15:8], ~pull[1], a[7:0], ~pull[2], d, ~pull[3], 1'b0};
   endfunction

   function automatic logic [36:0] got_bits(int base);
      logic [36:0] v = '0;
      for (int i = 0; i < 37; i++)
         v = {v[35:0], (base + i < cap.size()) ? cap[base + i] : 1'bx};
      return v;
   endfunction

   // Request at a negedge; returns one negedge after the accept edge, inputs then scrambled.
   task automatic do_req(input logic [15:0] a, input logic [7:0] d);
      @(negedge meg25);
      req_if.start = 1'b1; req_if.reg_addr = a; req_if.reg_data = d;
      @(negedge meg25);
      req_if.start = 1'b0; req_if.reg_addr = ~a; req_if.reg_data = ~d;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (req_if.done !== 1'b1 && n < 12000) begin @(negedge meg25); n++; end
   endtask

   task automatic test_reset();
      total++; if (scl !== 1'b1) begin bad++; $display("FAIL reset_scl got %b want 1", scl); end
      total++; if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda got %b want 1 (released)", sda); end
      total++; if (req_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", req_if.busy); end
      total++; if (req_if.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", req_if.done); end
      total++; if (req_if.ack_err !== 1'b0) begin bad++; $display("FAIL reset_ack_err got %b want 0", req_if.ack_err); end
   endtask

   task automatic test_basic();
      int n, s0, p0;
      ack_pull = 4'hF; cap.delete(); s0 = nstart; p0 = nstop;
      do_req(16'h3008, 8'h82);
      total++; if (req_if.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got %b want 1", req_if.busy); end
      wait_done(n);
      total++; if (n != 9300) begin bad++; $display("FAIL basic_latency got %0d want 9300", n); end
      total++; if (req_if.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got %b want 0", req_if.busy); end
      total++; if (req_if.ack_err !== 1'b0) begin bad++; $display("FAIL basic_ack_err got %b want 0", req_if.ack_err); end
      @(negedge meg25);
      total++; if (req_if.done !== 1'b0) begin bad++; $display("FAIL basic_done_width got %b want 0", req_if.done); end
      repeat (5) @(negedge meg25);
      total++; if (cap.size() != 37) begin bad++; $display("FAIL basic_rises got %0d want 37", cap.size()); end
      total++; if (got_bits(0) !== exp_bits(16'h3008, 8'h82, 4'hF))
         begin bad++; $display("FAIL basic_bits got %h want %h", got_bits(0), exp_bits(16'h3008, 8'h82, 4'hF)); end
      total++; if (nstart - s0 != 1 || nstop - p0 != 1)
         begin bad++; $display("FAIL basic_start_stop got %0d/%0d want 1/1", nstart - s0, nstop - p0); end
   endtask

   task automatic test_ack_err();
      int n;
      ack_pull = 4'b0111; cap.delete();
      do_req(16'h3103, 8'h11);
      wait_done(n);
      total++; if (n != 9300) begin bad++; $display("FAIL ackerr_latency got %0d want 9300", n); end
      total++; if (req_if.ack_err !== 1'b1) begin bad++; $display("FAIL ackerr_flag got %b want 1", req_if.ack_err); end
      repeat (10) @(negedge meg25);
      total++; if (req_if.ack_err !== 1'b1) begin bad++; $display("FAIL ackerr_sticky got %b want 1", req_if.ack_err); end
      total++; if (got_bits(0) !== exp_bits(16'h3103, 8'h11, 4'b0111))
         begin bad++; $display("FAIL ackerr_bits got %h want %h", got_bits(0), exp_bits(16'h3103, 8'h11, 4'b0111)); end
   endtask

   task automatic test_start_ignored();
      int n, d0;
      ack_pull = 4'hF; cap.delete(); d0 = ndone;
      do_req(16'h3820, 8'h46);
      total++; if (req_if.ack_err !== 1'b0) begin bad++; $display("FAIL ignore_err_clear got %b want 0", req_if.ack_err); end
      n = 0;
      while (req_if.done !== 1'b1 && n < 12000) begin
         @(negedge meg25); n++;
         if (n == 100) begin req_if.start = 1'b1; req_if.reg_addr = 16'hAAAA; req_if.reg_data = 8'h55; end
         if (n == 150) req_if.start = 1'b0;
      end
      total++; if (n != 9300) begin bad++; $display("FAIL ignore_latency got %0d want 9300", n); end
      repeat (20) @(negedge meg25);
      total++; if (ndone - d0 != 1) begin bad++; $display("FAIL ignore_done_count got %0d want 1", ndone - d0); end
      total++; if (got_bits(0) !== exp_bits(16'h3820, 8'h46, 4'hF))
         begin bad++; $display("FAIL ignore_bits got %h want %h", got_bits(0), exp_bits(16'h3820, 8'h46, 4'hF)); end
   endtask

   task automatic test_back_to_back();
      int n, s0;
      ack_pull = 4'hF; cap.delete(); s0 = nstart;
      do_req(16'h3017, 8'h5A);
      wait_done(n);
      total++; if (n != 9300) begin bad++; $display("FAIL b2b_latency1 got %0d want 9300", n); end
      req_if.start = 1'b1; req_if.reg_addr = 16'h4300; req_if.reg_data = 8'h30;
      @(negedge meg25);
      req_if.start = 1'b0; req_if.reg_addr = 16'h0000; req_if.reg_data = 8'h00;
      total++; if (req_if.busy !== 1'b1) begin bad++; $display("FAIL b2b_no_gap got %b want 1", req_if.busy); end
      wait_done(n);
      total++; if (n != 9300) begin bad++; $display("FAIL b2b_latency2 got %0d want 9300", n); end
      repeat (5) @(negedge meg25);
      total++; if (cap.size() != 74) begin bad++; $display("FAIL b2b_rises got %0d want 74", cap.size()); end
      total++; if (got_bits(0) !== exp_bits(16'h3017, 8'h5A, 4'hF))
         begin bad++; $display("FAIL b2b_bits1 got %h want %h", got_bits(0), exp_bits(16'h3017, 8'h5A, 4'hF)); end
      total++; if (got_bits(37) !== exp_bits(16'h4300, 8'h30, 4'hF))
         begin bad++; $display("FAIL b2b_bits2 got %h want %h", got_bits(37), exp_bits(16'h4300, 8'h30, 4'hF)); end
      total++; if (nstart - s0 != 2) begin bad++; $display("FAIL b2b_starts got %0d want 2", nstart - s0); end
   endtask

   task automatic test_reset_abort();
      int n, d0, s0, p0;
      ack_pull = 4'hF; d0 = ndone;
      do_req(16'h3008, 8'h82);
      for (n = 0; n < 3999; n++) @(negedge meg25);
      mon_en = 1'b0; rst_n = 1'b0;
      @(negedge meg25);
      rst_n = 1'b1;
      total++; if (scl !== 1'b1) begin bad++; $display("FAIL abort_scl got %b want 1", scl); end
      total++; if (sda !== 1'b1) begin bad++; $display("FAIL abort_sda got %b want 1 (released)", sda); end
      total++; if (req_if.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", req_if.busy); end
      repeat (2) @(negedge meg25);
      mon_en = 1'b1;
      repeat (6000) @(negedge meg25);
      total++; if (ndone - d0 != 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", ndone - d0); end
      cap.delete(); s0 = nstart; p0 = nstop;
      do_req(16'h3503, 8'h07);
      wait_done(n);
      total++; if (n != 9300) begin bad++; $display("FAIL abort_relatency got %0d want 9300", n); end
      repeat (5) @(negedge meg25);
      total++; if (got_bits(0) !== exp_bits(16'h3503, 8'h07, 4'hF))
         begin bad++; $display("FAIL abort_bits got %h want %h", got_bits(0), exp_bits(16'h3503, 8'h07, 4'hF)); end
      total++; if (nstart - s0 != 1 || nstop - p0 != 1)
         begin bad++; $display("FAIL abort_start_stop got %0d/%0d want 1/1", nstart - s0, nstop - p0); end
   endtask

   initial begin
      req_if.start = 1'b0; req_if.reg_addr = 16'h0000; req_if.reg_data = 8'h00;
      repeat (3) @(negedge meg25);
      rst_n = 1'b1;
      @(negedge meg25);
      test_reset();
      test_basic();
      test_ack_err();
      test_start_ignored();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
